// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and types for the register file
package rf_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);
    localparam int ZERO_REG  = 0;

    typedef logic [AW_DEF-1:0] reg_addr_t;
endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits, busy count and read hazard lookup
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    output logic [AW:0]       busy_cnt
);
    logic [NREGS-1:0] pending_q, pending_d;
    logic [AW:0]      busy_cnt_q, busy_cnt_d;

    // Issue is applied after the writeback clear so the newer producer wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_en)
            pending_d[wr_addr] = 1'b0;
        if (iss_en)
            pending_d[iss_addr] = 1'b1;
        pending_d[ZERO_REG] = 1'b0;
        if (flush)
            pending_d = '0;
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < NREGS; i++)
            busy_cnt_d = busy_cnt_d + (AW+1)'(pending_d[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q  <= '0;
            busy_cnt_q <= '0;
        end else begin
            pending_q  <= pending_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int i = 0; i < NRD; i++)
            rd_busy[i] = pending_q[rd_addr[i*AW +: AW]]
                       & ~(wr_en && (wr_addr == rd_addr[i*AW +: AW]));
    end

    assign busy_cnt = busy_cnt_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with bypass, zero register and scoreboard
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr_ok;

    assign wr_ok = wr_en && (wr_addr != AW'(ZERO_REG));

    always_comb begin
        regs_d = regs_q;
        if (wr_ok)
            regs_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++)
                regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads are gated by rst so a bypassed write cannot leak out during reset.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rst || rd_addr[i*AW +: AW] == AW'(ZERO_REG))
                rd_data[i*XLEN +: XLEN] = '0;
            else if (BYPASS != 0 && wr_en && wr_addr == rd_addr[i*AW +: AW])
                rd_data[i*XLEN +: XLEN] = wr_data;
            else
                rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed vector bench for regfile_scoreboard
module tb_regfile_scoreboard;
    import rf_pkg::*;

    logic         clk;
    logic         rst;
    logic [19:0]  rd_addr;
    logic [127:0] rd_data, rd_data_nb;
    logic [3:0]   rd_busy, rd_busy_nb;
    logic         wr_en;
    reg_addr_t    wr_addr;
    logic [31:0]  wr_data;
    logic         iss_en;
    reg_addr_t    iss_addr;
    logic         flush;
    logic [5:0]   busy_cnt, busy_cnt_nb;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(4), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt)
    );

    regfile_scoreboard #(.XLEN(32), .NREGS(32), .NRD(4), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush), .busy_cnt(busy_cnt_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        reg_addr_t   rd0;
        logic        we;
        reg_addr_t   wa;
        logic [31:0] wd;
        logic        ie;
        reg_addr_t   ia;
        logic        fl;
        logic [31:0] exp_d;
        logic [31:0] exp_nb;
        logic        exp_busy;
        logic [5:0]  exp_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input reg_addr_t rd0, input logic we, input reg_addr_t wa, input logic [31:0] wd,
                       input logic ie, input reg_addr_t ia, input logic fl,
                       input logic [31:0] exp_d, input logic [31:0] exp_nb, input logic exp_busy,
                       input logic [5:0] exp_cnt);
        vec_t v;
        v = '{rd0, we, wa, wd, ie, ia, fl, exp_d, exp_nb, exp_busy, exp_cnt};
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rd_addr = '0;
        idle();

        //   rd0 we wa wd          ie ia fl  exp_d        exp_nb       busy cnt
        add( 0, 0, 0, 32'h0,       0, 0, 0, 32'h0,       32'h0,       0, 0);
        add( 9, 1, 9, 32'd10,      0, 0, 0, 32'd10,      32'd0,       0, 0);
        add( 9, 0, 0, 32'h0,       0, 0, 0, 32'd10,      32'd10,      0, 0);
        add(12, 0, 0, 32'h0,       1, 12, 0, 32'd0,      32'd0,       0, 0);
        add(12, 0, 0, 32'h0,       0, 0, 0, 32'd0,       32'd0,       1, 1);
        add(12, 1, 12, 32'd4,      0, 0, 0, 32'd4,       32'd0,       0, 1);
        add(12, 0, 0, 32'h0,       0, 0, 0, 32'd4,       32'd4,       0, 0);
        add(17, 0, 0, 32'h0,       1, 17, 0, 32'd0,      32'd0,       0, 0);
        add(17, 1, 17, 32'd4,      1, 17, 0, 32'd4,      32'd0,       0, 1);
        add(17, 0, 0, 32'h0,       0, 0, 0, 32'd4,       32'd4,       1, 1);
        add( 3, 0, 0, 32'h0,       1, 3, 0, 32'd0,       32'd0,       0, 1);
        add( 3, 0, 0, 32'h0,       1, 4, 0, 32'd0,       32'd0,       1, 2);
        add( 4, 0, 0, 32'h0,       1, 15, 0, 32'd0,      32'd0,       1, 3);
        add(15, 1, 21, 32'd2,      1, 20, 1, 32'd0,      32'd0,       1, 4);
        add(20, 0, 0, 32'h0,       0, 0, 0, 32'd0,       32'd0,       0, 0);
        add(21, 0, 0, 32'h0,       0, 0, 0, 32'd2,       32'd2,       0, 0);
        add( 0, 1, 0, 32'h1234,    0, 0, 0, 32'd0,       32'd0,       0, 0);
        add( 0, 0, 0, 32'h0,       0, 0, 0, 32'd0,       32'd0,       0, 0);
        add( 0, 0, 0, 32'h0,       1, 0, 0, 32'd0,       32'd0,       0, 0);
        add( 0, 0, 0, 32'h0,       0, 0, 0, 32'd0,       32'd0,       0, 0);
        add( 5, 1, 5, 32'd7,       1, 5, 0, 32'd7,       32'd0,       0, 0);
        add( 5, 0, 0, 32'h0,       0, 0, 0, 32'd7,       32'd7,       1, 1);
        add( 5, 1, 5, 32'd8,       0, 0, 0, 32'd8,       32'd7,       0, 1);
        add( 5, 0, 0, 32'h0,       0, 0, 0, 32'd8,       32'd8,       0, 0);

        #2;
        check("reset_rd_data", rd_data, 128'd0);
        check("reset_busy_cnt", {122'd0, busy_cnt}, 128'd0);
        check("reset_rd_busy", {124'd0, rd_busy}, 128'd0);
        tick();
        rst = 1'b0;

        foreach (tbl[k]) begin
            rd_addr  = {15'd0, tbl[k].rd0};
            wr_en    = tbl[k].we;  wr_addr  = tbl[k].wa; wr_data = tbl[k].wd;
            iss_en   = tbl[k].ie;  iss_addr = tbl[k].ia; flush   = tbl[k].fl;
            #1;
            check($sformatf("v%0d_rd_data0", k), {96'd0, rd_data[31:0]}, {96'd0, tbl[k].exp_d});
            check($sformatf("v%0d_rd_data0_nobypass", k), {96'd0, rd_data_nb[31:0]}, {96'd0, tbl[k].exp_nb});
            check($sformatf("v%0d_rd_busy0", k), {127'd0, rd_busy[0]}, {127'd0, tbl[k].exp_busy});
            check($sformatf("v%0d_rd_busy0_nobypass", k), {127'd0, rd_busy_nb[0]}, {127'd0, tbl[k].exp_busy});
            check($sformatf("v%0d_busy_cnt", k), {122'd0, busy_cnt}, {122'd0, tbl[k].exp_cnt});
            check($sformatf("v%0d_busy_cnt_nobypass", k), {122'd0, busy_cnt_nb}, {122'd0, tbl[k].exp_cnt});
            tick();
        end
        idle();

        // Four read ports in parallel, port 3 on the zero register.
        for (int r = 1; r <= 3; r++) begin
            wr_en = 1'b1; wr_addr = reg_addr_t'(r); wr_data = 32'(r * 10 + 10);
            tick();
        end
        idle();
        rd_addr = {5'd0, 5'd3, 5'd2, 5'd1};
        #1;
        check("ports_rd_data", rd_data, {32'd0, 32'd40, 32'd30, 32'd20});
        check("ports_rd_data_nobypass", rd_data_nb, {32'd0, 32'd40, 32'd30, 32'd20});

        // Fill the scoreboard; the count must saturate at NREGS-1.
        iss_en = 1'b1; iss_addr = 5'd31;
        tick();
        idle();
        #1;
        check("fill_first_cnt", {122'd0, busy_cnt}, 128'd1);
        for (int r = 1; r <= 30; r++) begin
            iss_en = 1'b1; iss_addr = reg_addr_t'(r);
            tick();
        end
        iss_en = 1'b1; iss_addr = 5'd0;
        tick();
        idle();
        rd_addr = {5'd31, 5'd1, 5'd0, 5'd30};
        #1;
        check("fill_busy_cnt", {122'd0, busy_cnt}, 128'd31);
        check("fill_rd_busy", {124'd0, rd_busy}, {124'd0, 4'b1101});
        check("fill_rd_busy_nobypass", {124'd0, rd_busy_nb}, {124'd0, 4'b1101});

        // Asynchronous reset mid-operation.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_addr = {15'd0, 5'd5};
        #1;
        check("pre_reset_rd_data0", {96'd0, rd_data[31:0]}, {96'd0, 32'hDEADBEEF});
        rst = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77;
        #1;
        check("in_reset_rd_data0", {96'd0, rd_data[31:0]}, 128'd0);
        check("in_reset_busy_cnt", {122'd0, busy_cnt}, 128'd0);
        check("in_reset_rd_busy", {124'd0, rd_busy}, 128'd0);
        tick();
        idle();
        rst = 1'b0;
        #1;
        check("post_reset_rd_data0", {96'd0, rd_data[31:0]}, 128'd0);
        check("post_reset_busy_cnt", {122'd0, busy_cnt}, 128'd0);
        wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h55;
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        idle();
        rd_addr = {10'd0, 5'd7, 5'd6};
        #1;
        check("first_edge_rd_data0", {96'd0, rd_data[31:0]}, {96'd0, 32'h55});
        check("first_edge_rd_busy1", {127'd0, rd_busy[1]}, 128'd1);
        check("first_edge_busy_cnt", {122'd0, busy_cnt}, 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
